// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ byte sources,
// with a per-owner burst limit, an idle gap between owners and a per-byte watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [8*NREQ-1:0]         data,
  output logic [NREQ-1:0]           ack,
  output logic                      tx_load,
  output logic [7:0]                tx_byte,
  input  logic                      tx_done,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  // One extra count keeps the gap counter at least one bit wide when GAP_CYCLES is 0.
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]      state, state_d;
  logic [OW-1:0]   ptr, ptr_d;
  logic [OW-1:0]   owner_d;
  logic [7:0]      tx_byte_d;
  logic [BW-1:0]   burst_cnt, burst_cnt_d;
  logic [GW-1:0]   gap_cnt, gap_cnt_d;
  logic [WW-1:0]   watchdog, watchdog_d;
  logic [NREQ-1:0] ack_d;
  logic            tx_load_d;
  logic            busy_d;
  logic            timeout_err_d;

  logic [7:0]      data_arr [NREQ];
  logic [OW-1:0]   winner;
  logic [OW-1:0]   scan;
  logic            found;

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = data[8*i +: 8];
    end
  end

  // Round-robin pick: first requester strictly after ptr, wrapping, ptr itself last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = OW'((32'(ptr) + k) % NREQ);
      if (!found && req[scan]) begin
        winner = scan;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    owner_d       = owner;
    tx_byte_d     = tx_byte;
    burst_cnt_d   = burst_cnt;
    gap_cnt_d     = gap_cnt;
    watchdog_d    = watchdog;
    ack_d         = '0;
    tx_load_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (|req) begin
          owner_d        = winner;
          tx_byte_d      = data_arr[winner];
          burst_cnt_d    = '0;
          tx_load_d      = 1'b1;
          ack_d[winner]  = 1'b1;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        watchdog_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        watchdog_d = watchdog + WW'(1);
        if (tx_done) begin
          if (req[owner] && ((32'(burst_cnt) + 32'd1) < MAX_BURST)) begin
            burst_cnt_d   = burst_cnt + BW'(1);
            tx_byte_d     = data_arr[owner];
            tx_load_d     = 1'b1;
            ack_d[owner]  = 1'b1;
            state_d       = S_LOAD;
          end else begin
            ptr_d     = owner;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end else if (watchdog == WW'(TIMEOUT - 1)) begin
          // Abort the stuck frame; the byte was already acknowledged at load time.
          timeout_err_d = 1'b1;
          ptr_d         = owner;
          gap_cnt_d     = '0;
          state_d       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= OW'(NREQ - 1);
      owner       <= '0;
      tx_byte     <= '0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      watchdog    <= '0;
      ack         <= '0;
      tx_load     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      owner       <= owner_d;
      tx_byte     <= tx_byte_d;
      burst_cnt   <= burst_cnt_d;
      gap_cnt     <= gap_cnt_d;
      watchdog    <= watchdog_d;
      ack         <= ack_d;
      tx_load     <= tx_load_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: scripted scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXB    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] data = '0;
  logic              tx_done = 1'b0;
  logic [NREQ-1:0]   ack;
  logic              tx_load;
  logic [7:0]        tx_byte;
  logic [1:0]        owner;
  logic              busy;
  logic              timeout_err;

  logic [NREQ-1:0]   req1 = '0;
  logic [8*NREQ-1:0] data1 = '0;
  logic              tx_done1 = 1'b0;
  logic [NREQ-1:0]   ack1;
  logic              tx_load1;
  logic [7:0]        tx_byte1;
  logic [1:0]        owner1;
  logic              busy1;
  logic              timeout_err1;

  logic [7:0] cur  [NREQ];
  logic [7:0] cur1 [NREQ];

  int nvec = 0;
  int nerr = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .tx_load(tx_load),
    .tx_byte(tx_byte), .tx_done(tx_done), .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(1), .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .data(data1), .ack(ack1), .tx_load(tx_load1),
    .tx_byte(tx_byte1), .tx_done(tx_done1), .owner(owner1), .busy(busy1), .timeout_err(timeout_err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration rule: first set bit after the last owner, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < NREQ; i++) data[8*i +: 8] = cur[i];
  endtask

  task automatic pack1();
    for (int i = 0; i < NREQ; i++) data1[8*i +: 8] = cur1[i];
  endtask

  // One-cycle tx_done pulse; returns at the negedge of the cycle after the pulse.
  task automatic pulse_done(output int d);
    tx_done = 1'b1;
    d = cyc;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Returns the cycle at which tx_load is seen (current negedge included), -1 if none.
  task automatic wait_load(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (tx_load) at = cyc;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int loads, busys;
    loads = 0; busys = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (ack !== 4'b0)          begin nerr++; $display("FAIL reset_ack got %b want 0000", ack); end
    nvec++; if (tx_load !== 1'b0)      begin nerr++; $display("FAIL reset_tx_load got %b want 0", tx_load); end
    nvec++; if (tx_byte !== 8'h00)     begin nerr++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    nvec++; if (owner !== 2'd0)        begin nerr++; $display("FAIL reset_owner got %0d want 0", owner); end
    nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (timeout_err !== 1'b0)  begin nerr++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    repeat (20) begin
      @(negedge clk);
      if (tx_load !== 1'b0 || tx_load1 !== 1'b0) loads++;
      if (busy !== 1'b0 || busy1 !== 1'b0) busys++;
    end
    nvec++; if (loads != 0) begin nerr++; $display("FAIL reset_idle_loads got %0d want 0", loads); end
    nvec++; if (busys != 0) begin nerr++; $display("FAIL reset_idle_busy got %0d want 0", busys); end
  endtask

  task automatic test_single();
    int d, loads;
    loads = 0;
    for (int i = 0; i < NREQ; i++) cur[i] = 8'($urandom);
    cur[1] = 8'hA5;
    pack();
    req = 4'b0010;
    @(negedge clk);
    nvec++; if (tx_load !== 1'b1)   begin nerr++; $display("FAIL single_tx_load got %b want 1", tx_load); end
    nvec++; if (ack !== 4'b0010)    begin nerr++; $display("FAIL single_ack got %b want 0010", ack); end
    nvec++; if (tx_byte !== 8'hA5)  begin nerr++; $display("FAIL single_tx_byte got %h want a5", tx_byte); end
    nvec++; if (owner !== 2'd1)     begin nerr++; $display("FAIL single_owner got %0d want 1", owner); end
    nvec++; if (busy !== 1'b1)      begin nerr++; $display("FAIL single_busy got %b want 1", busy); end
    req = 4'b0000;
    cur[1] = 8'($urandom);
    pack();
    repeat (100) begin
      @(negedge clk);
      if (tx_load !== 1'b0 || ack !== 4'b0) loads++;
    end
    nvec++; if (loads != 0) begin nerr++; $display("FAIL single_extra_load got %0d want 0", loads); end
    pulse_done(d);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_gap1_busy got %b want 1", busy); end
    @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_gap2_busy got %b want 1", busy); end
    @(negedge clk);
    nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL single_idle_busy got %b want 0", busy); end
    nvec++; if (tx_byte !== 8'hA5) begin nerr++; $display("FAIL single_byte_hold got %h want a5", tx_byte); end
  endtask

  task automatic test_round_robin();
    int exp, exp_at, at, d, last;
    last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) cur1[i] = 8'($urandom);
    pack1();
    req1 = 4'b1111;
    exp_at = cyc + 1;
    for (int n = 0; n < 5; n++) begin
      exp = rr_pick(4'b1111, last);
      at = -1;
      for (int w = 0; w < 20 && at < 0; w++) begin
        @(negedge clk);
        if (tx_load1) at = cyc;
      end
      nvec++; if (at != exp_at)             begin nerr++; $display("FAIL rr_latency[%0d] got %0d want %0d", n, at, exp_at); end
      nvec++; if (owner1 !== 2'(exp))       begin nerr++; $display("FAIL rr_owner[%0d] got %0d want %0d", n, owner1, exp); end
      nvec++; if (ack1 !== (4'(1) << exp))  begin nerr++; $display("FAIL rr_ack[%0d] got %b want %b", n, ack1, 4'(1) << exp); end
      nvec++; if (tx_byte1 !== cur1[exp])   begin nerr++; $display("FAIL rr_byte[%0d] got %h want %h", n, tx_byte1, cur1[exp]); end
      cur1[exp] = 8'($urandom);
      pack1();
      repeat (100) @(negedge clk);
      tx_done1 = 1'b1;
      d = cyc;
      if (n == 4) req1 = 4'b0000;
      @(negedge clk);
      tx_done1 = 1'b0;
      last = exp;
      exp_at = d + GAP + 2;
    end
    repeat (GAP + 2) @(negedge clk);
    nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL rr_end_busy got %b want 0", busy1); end
  endtask

  task automatic test_burst();
    int at, d, exp_at;
    d = 0;
    for (int i = 0; i < NREQ; i++) cur[i] = 8'($urandom);
    cur[0] = 8'h10;
    pack();
    req = 4'b0011;
    exp_at = cyc + 1;
    for (int n = 0; n < MAXB; n++) begin
      wait_load(300, at);
      nvec++; if (at != exp_at)               begin nerr++; $display("FAIL burst_latency[%0d] got %0d want %0d", n, at, exp_at); end
      nvec++; if (owner !== 2'd0)             begin nerr++; $display("FAIL burst_owner[%0d] got %0d want 0", n, owner); end
      nvec++; if (ack !== 4'b0001)            begin nerr++; $display("FAIL burst_ack[%0d] got %b want 0001", n, ack); end
      nvec++; if (tx_byte !== 8'(8'h10 + n))  begin nerr++; $display("FAIL burst_byte[%0d] got %h want %h", n, tx_byte, 8'(8'h10 + n)); end
      cur[0] = 8'(8'h11 + n);
      pack();
      @(negedge clk);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      pulse_done(d);
      exp_at = d + 1;
    end
    exp_at = d + GAP + 2;
    wait_load(300, at);
    nvec++; if (at != exp_at)       begin nerr++; $display("FAIL burst_switch_latency got %0d want %0d", at, exp_at); end
    nvec++; if (owner !== 2'd1)     begin nerr++; $display("FAIL burst_switch_owner got %0d want 1", owner); end
    nvec++; if (ack !== 4'b0010)    begin nerr++; $display("FAIL burst_switch_ack got %b want 0010", ack); end
    nvec++; if (tx_byte !== cur[1]) begin nerr++; $display("FAIL burst_switch_byte got %h want %h", tx_byte, cur[1]); end
    req = 4'b0000;
    repeat (5) @(negedge clk);
    pulse_done(d);
    repeat (GAP) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL burst_end_busy got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int at, d, te_at, te_cnt, acks, loads, busy_at_te, busy_after;
    te_at = -1; te_cnt = 0; acks = 0; loads = 0; busy_at_te = -1; busy_after = -1;
    cur[2] = 8'($urandom);
    pack();
    req = 4'b0100;
    wait_load(10, at);
    nvec++; if (owner !== 2'd2)     begin nerr++; $display("FAIL to_owner got %0d want 2", owner); end
    nvec++; if (tx_byte !== cur[2]) begin nerr++; $display("FAIL to_byte got %h want %h", tx_byte, cur[2]); end
    req = 4'b0000;
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      @(negedge clk);
      if (timeout_err) begin te_cnt++; if (te_at < 0) te_at = cyc; end
      if (ack !== 4'b0) acks++;
      if (cyc == at + TIMEOUT + 1) busy_at_te = int'(busy);
      if (cyc == at + TIMEOUT + 1 + GAP) busy_after = int'(busy);
    end
    // WAIT starts the cycle after the load with watchdog 0; it reaches TIMEOUT-1 in
    // cycle at+TIMEOUT, and the error pulse follows in the next cycle.
    nvec++; if (te_at != at + TIMEOUT + 1) begin nerr++; $display("FAIL to_pulse_cycle got %0d want %0d", te_at, at + TIMEOUT + 1); end
    nvec++; if (te_cnt != 1)     begin nerr++; $display("FAIL to_pulse_count got %0d want 1", te_cnt); end
    nvec++; if (acks != 0)       begin nerr++; $display("FAIL to_abort_ack got %0d want 0", acks); end
    nvec++; if (busy_at_te != 1) begin nerr++; $display("FAIL to_busy_in_gap got %0d want 1", busy_at_te); end
    nvec++; if (busy_after != 0) begin nerr++; $display("FAIL to_busy_after_gap got %0d want 0", busy_after); end
    pulse_done(d);
    repeat (5) begin
      if (tx_load !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) loads++;
      @(negedge clk);
    end
    nvec++; if (loads != 0) begin nerr++; $display("FAIL to_late_done got %0d want 0", loads); end
  endtask

  task automatic test_reset_mid();
    int at, d, exp_at;
    cur[0] = 8'($urandom);
    pack();
    req = 4'b0001;
    wait_load(10, at);
    req = 4'b0000;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++; if (ack !== 4'b0)         begin nerr++; $display("FAIL rmid_ack got %b want 0000", ack); end
    nvec++; if (tx_load !== 1'b0)     begin nerr++; $display("FAIL rmid_tx_load got %b want 0", tx_load); end
    nvec++; if (tx_byte !== 8'h00)    begin nerr++; $display("FAIL rmid_tx_byte got %h want 00", tx_byte); end
    nvec++; if (owner !== 2'd0)       begin nerr++; $display("FAIL rmid_owner got %0d want 0", owner); end
    nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
    nvec++; if (timeout_err !== 1'b0) begin nerr++; $display("FAIL rmid_timeout_err got %b want 0", timeout_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur[3] = 8'($urandom);
    pack();
    req = 4'b1000;
    exp_at = cyc + 1;
    @(negedge clk);
    wait_load(5, at);
    nvec++; if (at != exp_at)       begin nerr++; $display("FAIL rmid_latency got %0d want %0d", at, exp_at); end
    nvec++; if (owner !== 2'd3)     begin nerr++; $display("FAIL rmid_owner3 got %0d want 3", owner); end
    nvec++; if (tx_byte !== cur[3]) begin nerr++; $display("FAIL rmid_byte got %h want %h", tx_byte, cur[3]); end
    req = 4'b0000;
    repeat (5) @(negedge clk);
    pulse_done(d);
    repeat (GAP) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_end_busy got %b want 0", busy); end
  endtask

  task automatic test_random();
    int at, d, exp_owner, exp_at, m_owner, m_burst, loads;
    logic [NREQ-1:0] mask;
    bit new_burst;
    loads = 0;
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) cur[i] = 8'($urandom);
    pack();
    mask = 4'($urandom_range(1, 15));
    req = mask;
    exp_owner = rr_pick(mask, NREQ - 1);
    exp_at = cyc + 1;
    m_owner = 0; m_burst = 0; new_burst = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      wait_load(50, at);
      nvec++; if (at != exp_at)                  begin nerr++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, at, exp_at); end
      nvec++; if (owner !== 2'(exp_owner))       begin nerr++; $display("FAIL rnd_owner[%0d] got %0d want %0d", n, owner, exp_owner); end
      nvec++; if (ack !== (4'(1) << exp_owner))  begin nerr++; $display("FAIL rnd_ack[%0d] got %b want %b", n, ack, 4'(1) << exp_owner); end
      nvec++; if (tx_byte !== cur[exp_owner])    begin nerr++; $display("FAIL rnd_byte[%0d] got %h want %h", n, tx_byte, cur[exp_owner]); end
      if (new_burst) m_burst = 1; else m_burst++;
      m_owner = exp_owner;
      cur[exp_owner] = 8'($urandom);
      pack();
      @(negedge clk);
      repeat ($urandom_range(0, 25)) @(negedge clk);
      mask = (n == 39) ? 4'b0000 : 4'($urandom_range(1, 15));
      req = mask;
      pulse_done(d);
      if (mask[m_owner] && m_burst < MAXB) begin
        exp_at = d + 1;
        new_burst = 1'b0;
      end else begin
        exp_owner = rr_pick(mask, m_owner);
        exp_at = d + GAP + 2;
        new_burst = 1'b1;
      end
    end
    repeat (GAP + 3) begin
      if (tx_load !== 1'b0) loads++;
      @(negedge clk);
    end
    nvec++; if (loads != 0)    begin nerr++; $display("FAIL rnd_tail_load got %0d want 0", loads); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rnd_tail_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
